// File: rtl/imm_extend_unit.sv
// Pipelined immediate extender (zero / sign / upper / sign-shl2) with valid/ready and a one-entry skid buffer.
// Optional accepted-transaction counter on xfer_count when IMMEXT_COUNT_EN is defined.
module imm_extend_unit #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_neg
`ifdef IMMEXT_COUNT_EN
  ,
  output logic [15:0]      xfer_count
`endif
);

  generate
    if (OUT_W < IN_W + 2) begin : g_bad_width
      $error("imm_extend_unit: OUT_W must be at least IN_W + 2");
    end
  endgenerate

  localparam logic [1:0] MODE_ZERO  = 2'b00;
  localparam logic [1:0] MODE_SIGN  = 2'b01;
  localparam logic [1:0] MODE_UPPER = 2'b10;

  function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] imm,
                                              input logic [1:0] mode);
    logic signed [OUT_W-1:0] sext;
    logic [OUT_W-1:0]        res;
    sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    case (mode)
      MODE_ZERO:  res = {{(OUT_W-IN_W){1'b0}}, imm};
      MODE_SIGN:  res = sext;
      MODE_UPPER: res = {imm, {(OUT_W-IN_W){1'b0}}};
      default:    res = sext <<< 2;
    endcase
    return res;
  endfunction

  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [OUT_W-1:0] skid_data_q, skid_data_d;
  logic             accept;
  logic             main_free;
  logic [OUT_W-1:0] result;

  // in_ready depends only on the skid register, so no combinational path from out_ready.
  assign in_ready  = !skid_valid_q;
  assign accept    = in_valid && in_ready;
  assign main_free = !out_valid_q || out_ready;
  assign result    = extend(in_imm, in_mode);

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (main_free) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = result;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_neg   = out_data_q[OUT_W-1];

`ifdef IMMEXT_COUNT_EN
  logic [15:0] xfer_count_q, xfer_count_d;

  always_comb begin
    xfer_count_d = xfer_count_q;
    if (accept) xfer_count_d = xfer_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) xfer_count_q <= '0;
    else       xfer_count_q <= xfer_count_d;
  end

  assign xfer_count = xfer_count_q;
`endif

endmodule

// File: tb/tb_imm_extend_unit.sv
// Directed self-checking bench for imm_extend_unit (default 16 -> 32 configuration).
module tb_imm_extend_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_neg;
`ifdef IMMEXT_COUNT_EN
  logic [15:0] xfer_count;
`endif

  int passes = 0;
  int total  = 0;

  imm_extend_unit #(.IN_W(16), .OUT_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_neg   (out_neg)
`ifdef IMMEXT_COUNT_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single transaction with out_ready high; result must appear the following cycle.
  task automatic one_shot(input string tag, input logic [1:0] mode,
                          input logic [15:0] imm, input logic [31:0] exp);
    in_valid = 1'b1;
    in_mode  = mode;
    in_imm   = imm;
    tick();
    in_valid = 1'b0;
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_data"},  64'(out_data),  64'(exp));
    chk({tag, "_neg"},   64'(out_neg),   64'(exp[31]));
    tick();
    chk({tag, "_drained"}, 64'(out_valid), 64'd0);
  endtask

  logic [15:0] stream_in  [8];
  logic [31:0] stream_exp [8];

  initial begin
    stream_in  = '{16'h0001, 16'h8000, 16'h7FFF, 16'hFFFF,
                   16'h1234, 16'hABCD, 16'h0000, 16'h4321};
    stream_exp = '{32'h00000001, 32'hFFFF8000, 32'h00007FFF, 32'hFFFFFFFF,
                   32'h00001234, 32'hFFFFABCD, 32'h00000000, 32'h00004321};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_imm    = '0;
    in_mode   = 2'b00;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_data",  64'(out_data),  64'd0);
`ifdef IMMEXT_COUNT_EN
    chk("rst_count", 64'(xfer_count), 64'd0);
`endif
    reset     = 1'b0;
    out_ready = 1'b1;
    tick();

    one_shot("sign_8001",  2'b01, 16'h8001, 32'hFFFF8001);
    one_shot("zero_8001",  2'b00, 16'h8001, 32'h00008001);
    one_shot("upper_1234", 2'b10, 16'h1234, 32'h12340000);
    one_shot("upper_ffff", 2'b10, 16'hFFFF, 32'hFFFF0000);
    one_shot("shl2_ffff",  2'b11, 16'hFFFF, 32'hFFFFFFFC);
    one_shot("shl2_4000",  2'b11, 16'h4000, 32'h00010000);
    one_shot("shl2_8000",  2'b11, 16'h8000, 32'hFFFE0000);

    // Stall: fill main then skid with out_ready low.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'b01;
    in_imm    = 16'h0001;
    tick();
    chk("stall_ready_after_first", 64'(in_ready), 64'd1);
    in_imm = 16'h0002;
    tick();
    chk("stall_ready_full",  64'(in_ready),  64'd0);
    chk("stall_valid",       64'(out_valid), 64'd1);
    chk("stall_data_hold",   64'(out_data),  64'h00000001);
    in_imm = 16'h7777;
    tick();
    chk("stall_ignore_data",  64'(out_data), 64'h00000001);
    chk("stall_ignore_ready", 64'(in_ready), 64'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("drain_first", 64'(out_data), 64'h00000001);
    tick();
    chk("drain_second_valid", 64'(out_valid), 64'd1);
    chk("drain_second_data",  64'(out_data),  64'h00000002);
    chk("drain_ready_back",   64'(in_ready),  64'd1);
    tick();
    chk("drain_empty", 64'(out_valid), 64'd0);

    // Back-to-back stream, no bubbles.
    in_mode = 2'b01;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_imm   = stream_in[i];
      tick();
      chk($sformatf("stream%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("stream%0d_data", i),  64'(out_data),  64'(stream_exp[i]));
      chk($sformatf("stream%0d_ready", i), 64'(in_ready),  64'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end", 64'(out_valid), 64'd0);

    // Reset with both registers full discards everything.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_imm    = 16'hAAAA;
    tick();
    in_imm = 16'h5555;
    tick();
    in_valid = 1'b0;
    chk("full_before_rst", 64'(in_ready), 64'd0);
    reset = 1'b1;
    tick();
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready",  64'(in_ready),  64'd1);
    chk("midrst_out_data",  64'(out_data),  64'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("midrst_no_ghost%0d", i), 64'(out_valid), 64'd0);
    end

`ifdef IMMEXT_COUNT_EN
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    in_valid = 1'b1;
    in_mode  = 2'b00;
    in_imm   = 16'h0042;
    repeat (65535) @(posedge clk);
    #1;
    chk("count_ffff", 64'(xfer_count), 64'h0000FFFF);
    tick();
    in_valid = 1'b0;
    chk("count_wrap", 64'(xfer_count), 64'h00000000);
    tick();
    chk("count_hold", 64'(xfer_count), 64'h00000000);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("count_one", 64'(xfer_count), 64'h00000001);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("count_rst", 64'(xfer_count), 64'h00000000);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/imm_extend_unit.md
Name: imm_extend_unit

Overview:
- Parametrised, pipelined successor to the combinational 16->32 sign extender.
- Extends an IN_W-bit immediate to OUT_W bits in one of four modes: zero, sign, upper-placement (LUI-style), sign-and-shift-left-2 (branch offset).
- Registered output with valid/ready handshake and a one-entry skid buffer.
- Sits between instruction decode and the ALU/branch-target operand path of the multi-cycle datapath.

Parameters:
- IN_W, 16, immediate input width; IN_W >= 2.
- OUT_W, 32, extended output width; OUT_W >= IN_W + 2, elaboration error otherwise.

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  input transaction present
- in_ready  output  1  unit can accept input this cycle
- in_imm  input  IN_W  raw immediate
- in_mode  input  2  00 ZERO, 01 SIGN, 10 UPPER, 11 SIGN_SHL2
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result this cycle
- out_data  output  OUT_W  extended result
- out_neg  output  1  result MSB (out_data[OUT_W-1])
- xfer_count  output  16  accepted-transaction counter (IMMEXT_COUNT_EN only)

Behaviour:
- One clock (clk); reset is synchronous and active-high (reset).
- Arithmetic, s = in_imm[IN_W-1]:
  - ZERO: {(OUT_W-IN_W) zeros, in_imm}.
  - SIGN: {(OUT_W-IN_W) copies of s, in_imm}.
  - UPPER: {in_imm, (OUT_W-IN_W) zeros}.
  - SIGN_SHL2: SIGN result shifted left 2; top 2 bits discarded; bits [1:0] = 0.
- Handshakes:
  - Input accepted when in_valid && in_ready.
  - Output transferred when out_valid && out_ready.
  - in_data/in_mode are sampled only on acceptance.
- Storage: main register (out_valid, out_data) and skid register (skid_valid, skid_data).
- in_ready = !skid_valid. Driven from a register, never combinationally from out_ready.
- Latency: accepted input appears on out_data the next cycle when the main register is empty or drains that cycle.
- Per-cycle update, evaluated with pre-edge values:
  - main empty or draining:
    - if skid_valid: main <- skid, skid cleared; no new input possible since in_ready = 0.
    - else if input accepted: main <- computed result.
    - else: main empty.
  - main full and stalled (out_valid && !out_ready):
    - if input accepted: skid <- computed result, skid_valid = 1.
    - main held.
- Full: main and skid both valid -> in_ready = 0. in_valid may stay high; in_imm is ignored until accepted.
- Simultaneous accept and drain with skid empty: new result replaces main in the same edge; no bubble.
- Stability: out_data and out_valid are held stable while out_valid && !out_ready.
- out_neg is combinational from out_data.
- Reset (any cycle, including mid-transfer): out_valid = 0, skid_valid = 0, in_ready = 1, out_data = 0, xfer_count = 0. In-flight data is discarded.
- Consumer side: out_ready is don't-care while out_valid = 0.

Optional Feature:
- IMMEXT_COUNT_EN defined:
  - xfer_count increments by 1 on each accepted input.
  - Wraps 0xFFFF -> 0x0000.
  - Cleared by reset.
- IMMEXT_COUNT_EN undefined:
  - xfer_count port absent.
  - No counter logic.

Test Plan:
- SIGN, in_imm=0x8001, out_ready=1 -> next cycle out_valid=1, out_data=0xFFFF8001, out_neg=1.
- ZERO 0x8001 -> 0x00008001. UPPER 0x1234 -> 0x12340000. SIGN_SHL2 0xFFFF -> 0xFFFFFFFC. SIGN_SHL2 0x4000 -> 0x00010000.
- out_ready=0; send 0x0001 then 0x0002 (both SIGN):
  - in_ready drops to 0 after the second accept.
  - out_data holds 0x00000001.
  - Raise out_ready: 0x00000001 then 0x00000002 on consecutive cycles; in_ready returns to 1.
- Back-to-back stream of 8 inputs with out_ready=1 -> 8 outputs on consecutive cycles, no bubbles, order preserved.
- Assert reset with both registers full -> next cycle out_valid=0, in_ready=1, out_data=0; both held items never appear.
- IMMEXT_COUNT_EN defined:
  - Preload 65535 accepts, then 1 more -> xfer_count=0x0000.
  - Reset -> 0.
